// File: rtl/array_count_compare_if.sv
// Sequencer-side bundle for array_count_compare: scan request/result handshake
// plus the synchronous-read heap port.
interface array_count_compare_if #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 12
);
  logic              start;
  logic              ready;
  logic [WIDTH-1:0]  array;
  logic [WIDTH-1:0]  size;
  logic [WIDTH-1:0]  key;
  logic [1:0]        mode;
  logic              memRd;
  logic [ADDR_W-1:0] memAddr;
  logic [WIDTH-1:0]  memData;
  logic              done;
  logic [WIDTH-1:0]  count;
  logic [WIDTH-1:0]  first;
  logic              err;

  modport master (
    output start, array, size, key, mode, memData,
    input  ready, memRd, memAddr, done, count, first, err
  );

  modport slave (
    input  start, array, size, key, mode, memData,
    output ready, memRd, memAddr, done, count, first, err
  );
endinterface

// File: rtl/array_count_compare.sv
// Sequential array scan: counts elements matching an unsigned comparison
// against a key and reports the index of the first match.
module array_count_compare #(
  parameter int WIDTH   = 12,
  parameter int NAREA   = 3,
  parameter int NARRAYS = 1,
  parameter int ADDR_W  = 12
) (
  input  logic                clock,
  input  logic                reset,
  array_count_compare_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] key_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] cidx;
  logic             rd_vld;

  logic [WIDTH-1:0] n_in;
  logic [31:0]      base;
  logic             bad_arr;
  logic             hit;

  assign n_in    = (bus.size < WIDTH'(NAREA)) ? bus.size : WIDTH'(NAREA);
  assign base    = 32'(bus.array) * 32'(NAREA);
  assign bad_arr = 32'(bus.array) >= 32'(NARRAYS);
  assign bus.ready = (state == IDLE);

  always_comb begin
    hit = 1'b0;
    case (mode_r)
      2'd0: hit = bus.memData <  key_r;
      2'd1: hit = bus.memData <= key_r;
      2'd2: hit = bus.memData == key_r;
      2'd3: hit = bus.memData >  key_r;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      key_r       <= '0;
      mode_r      <= '0;
      n_r         <= '0;
      idx         <= '0;
      cidx        <= '0;
      rd_vld      <= 1'b0;
      bus.memRd   <= 1'b0;
      bus.memAddr <= '0;
      bus.done    <= 1'b0;
      bus.count   <= '0;
      bus.first   <= '0;
      bus.err     <= 1'b0;
    end else begin
      // memData answers the previous cycle's read, so accumulate one cycle behind issue
      rd_vld <= bus.memRd;
      if (rd_vld) begin
        if (hit) begin
          bus.count <= bus.count + WIDTH'(1);
          if (bus.first == n_r) bus.first <= cidx;
        end
        cidx <= cidx + WIDTH'(1);
      end

      case (state)
        IDLE: if (bus.start) begin
          key_r     <= bus.key;
          mode_r    <= bus.mode;
          n_r       <= n_in;
          idx       <= '0;
          cidx      <= '0;
          bus.count <= '0;
          bus.first <= n_in;
          bus.err   <= 1'b0;
          if (bad_arr) begin
            bus.err   <= 1'b1;
            bus.first <= '0;
            bus.done  <= 1'b1;
            state     <= DONE;
          end else if (n_in == '0) begin
            bus.first <= '0;
            bus.done  <= 1'b1;
            state     <= DONE;
          end else begin
            bus.memRd   <= 1'b1;
            bus.memAddr <= ADDR_W'(base);
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (idx == n_r - WIDTH'(1)) begin
            bus.memRd <= 1'b0;
            state     <= DRAIN;
          end else begin
            idx         <= idx + WIDTH'(1);
            bus.memAddr <= bus.memAddr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_count_compare.sv
// Bench for array_count_compare: vector table with scoreboarded results,
// address/latency tracing, and reset-abort sequence.
module tb_array_count_compare;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  array_count_compare_if #(.WIDTH(12), .ADDR_W(12)) bus ();

  array_count_compare #(.WIDTH(12), .NAREA(3), .NARRAYS(2), .ADDR_W(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [11:0] heap [0:5];
  always @(posedge clock)
    if (bus.memRd) bus.memData <= (bus.memAddr < 12'd6) ? heap[bus.memAddr] : 12'd0;

  typedef struct {
    logic [11:0] arr, size, key;
    logic [1:0]  mode;
    logic [11:0] h0, h1, h2;
    bit          noise;
    logic [11:0] ec, ef;
    logic        ee;
    int          nrd;
    int          base;
  } vec_t;

  typedef struct {
    logic [11:0] c, f;
    logic        e;
  } res_t;

  vec_t vt [13];
  res_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int arr, size, key, mode, h0, h1, h2, input bit noise,
                              input int ec, ef, ee, nrd, base);
    vec_t v;
    v.arr = 12'(arr); v.size = 12'(size); v.key = 12'(key); v.mode = 2'(mode);
    v.h0 = 12'(h0); v.h1 = 12'(h1); v.h2 = 12'(h2); v.noise = noise;
    v.ec = 12'(ec); v.ef = 12'(ef); v.ee = 1'(ee); v.nrd = nrd; v.base = base;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int   cyc = 0;
    int   rd  = 0;
    bit   got = 0;
    res_t r, q;
    if (v.arr < 12'd2) begin
      heap[int'(v.arr)*3+0] = v.h0;
      heap[int'(v.arr)*3+1] = v.h1;
      heap[int'(v.arr)*3+2] = v.h2;
    end
    bus.array = v.arr; bus.size = v.size; bus.key = v.key; bus.mode = v.mode;
    bus.start = 1'b1;
    r.c = v.ec; r.f = v.ef; r.e = v.ee;
    sb.push_back(r);
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) chk("ready_low", 32'(bus.ready), 0);
      if (bus.memRd) begin
        chk("mem_addr", 32'(bus.memAddr), 32'(v.base + rd));
        rd++;
      end
      if (bus.done) begin
        got = 1;
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          q = sb.pop_front();
          chk("count", 32'(bus.count), 32'(q.c));
          chk("first", 32'(bus.first), 32'(q.f));
          chk("err",   32'(bus.err),   32'(q.e));
        end
      end
      if (v.noise && cyc <= 3) begin
        bus.start = 1'b1;
        bus.key   = ~bus.key;
        bus.mode  = bus.mode + 2'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("done_seen", 32'(got), 1);
    chk("reads", 32'(rd), 32'(v.nrd));
    chk("latency", 32'(cyc), (v.nrd == 0) ? 1 : 32'(v.nrd + 2));
    @(negedge clock);
    chk("ready_after", 32'(bus.ready), 1);
    chk("done_pulse", 32'(bus.done), 0);
  endtask

  initial begin
    int seen;
    //            arr size key  md h0 h1   h2 nz ec ef ee nrd base
    vt[0]  = mk(0, 3, 20,   0, 10, 20,   30, 0, 1, 0, 0, 3, 0);
    vt[1]  = mk(0, 3, 20,   1, 10, 20,   30, 0, 2, 0, 0, 3, 0);
    vt[2]  = mk(0, 3, 20,   2, 10, 20,   30, 0, 1, 1, 0, 3, 0);
    vt[3]  = mk(0, 3, 20,   3, 10, 20,   30, 0, 1, 2, 0, 3, 0);
    vt[4]  = mk(0, 3, 5,    0, 10, 20,   30, 0, 0, 3, 0, 3, 0);
    vt[5]  = mk(0, 0, 20,   0, 10, 20,   30, 0, 0, 0, 0, 0, 0);
    vt[6]  = mk(0, 7, 20,   0, 10, 20,   30, 0, 1, 0, 0, 3, 0);
    vt[7]  = mk(0, 3, 4094, 3, 0,  4095, 0,  0, 1, 1, 0, 3, 0);
    vt[8]  = mk(1, 3, 7,    1, 5,  6,    7,  0, 3, 0, 0, 3, 3);
    vt[9]  = mk(2, 3, 7,    1, 5,  6,    7,  0, 0, 0, 1, 0, 0);
    vt[10] = mk(0, 3, 20,   2, 10, 20,   30, 1, 1, 1, 0, 3, 0);
    vt[11] = mk(1, 1, 9,    2, 9,  1,    2,  0, 1, 0, 0, 1, 3);
    vt[12] = mk(0, 2, 25,   3, 10, 20,   30, 0, 0, 2, 0, 2, 0);

    for (int i = 0; i < 6; i++) heap[i] = '0;
    reset = 1'b1;
    bus.start = 1'b0; bus.array = '0; bus.size = '0; bus.key = '0; bus.mode = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready",   32'(bus.ready),   1);
    chk("rst_memRd",   32'(bus.memRd),   0);
    chk("rst_memAddr", 32'(bus.memAddr), 0);
    chk("rst_done",    32'(bus.done),    0);
    chk("rst_count",   32'(bus.count),   0);
    chk("rst_first",   32'(bus.first),   0);
    chk("rst_err",     32'(bus.err),     0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run(vt[i]);

    // Abort in the second SCAN cycle: no result, no done pulse
    heap[0] = 12'd10; heap[1] = 12'd20; heap[2] = 12'd30;
    bus.array = '0; bus.size = 12'd3; bus.key = 12'd40; bus.mode = 2'd0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_ready", 32'(bus.ready), 1);
    chk("abort_memRd", 32'(bus.memRd), 0);
    chk("abort_done",  32'(bus.done),  0);
    chk("abort_count", 32'(bus.count), 0);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);

    run(vt[1]);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/array_count_compare.md
# array_count_compare

Sequential, parametrised successor to the single-cycle `arrayCountLess` instruction. It scans one array held in heap memory through a synchronous-read port, one element per clock. It reports how many elements satisfy a selectable unsigned comparison against a key, and the index of the first matching element. It sits beside the instruction sequencer, which starts it and waits for `done` before advancing `ip`.

## Interface
Parameters:
- `WIDTH`, 12: memory element width; also the width of `array`, `size`, `key`, `count`, `first`.
- `NAREA`, 3: elements per array area on the heap. Must be < 2**WIDTH.
- `NARRAYS`, 1: number of arrays.
- `ADDR_W`, 12: heap address width. Must hold NARRAYS*NAREA-1.

Ports:
- `clock`, in, 1: the single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a scan. Sampled only when `ready`=1.
- `ready`, out, 1: engine idle, `start` accepted.
- `array`, in, WIDTH: array number.
- `size`, in, WIDTH: current array length (arraySizes entry).
- `key`, in, WIDTH: comparison operand.
- `mode`, in, 2: comparison selector. 0 elem<key, 1 elem<=key, 2 elem==key, 3 elem>key.
- `memRd`, out, 1: heap read request.
- `memAddr`, out, ADDR_W: heap read address.
- `memData`, in, WIDTH: heap data, valid in the cycle after the request.
- `done`, out, 1: one-cycle completion pulse.
- `count`, out, WIDTH: number of matching elements.
- `first`, out, WIDTH: index of the first match; equals n if there is no match.
- `err`, out, 1: array number out of range.

## Operation
- States: IDLE, SCAN, DRAIN, DONE. `ready` = (state==IDLE).
- IDLE, start=1 at edge E0:
  - Capture `array`, `key`, `mode`, and n = min(`size`, NAREA).
  - Clear the accumulator and set the first-match index to n.
  - If `array` >= NARRAYS: set err=1, go to DONE with count=0 and first=0. No memory reads.
  - Else if n=0: go to DONE with count=0, first=0, err=0.
  - Else: go to SCAN with issue index i=0.
- SCAN:
  - memRd=1, memAddr = array*NAREA + i (truncated to ADDR_W).
  - Each edge: i increments. When i reaches n-1 at an edge, go to DRAIN.
  - From the second SCAN cycle on, `memData` (element i-1) is compared and accumulated at each edge.
- DRAIN: memRd=0. The last element is compared and accumulated at the edge, then go to DONE.
- Accumulate step:
  - If the comparison holds, count increments.
  - If the comparison holds and first==n, first takes the element index.
  - All comparisons are unsigned WIDTH-bit. The count cannot overflow because n <= NAREA < 2**WIDTH.
- DONE:
  - done=1 and `count`/`first`/`err` are valid.
  - Go to IDLE at the next edge.
- Result outputs hold their values until the next accepted start.
- Inputs other than `start` are ignored outside the accepting edge. Changes mid-scan have no effect.
- `start` in any state other than IDLE is ignored; it is not queued.

## Timing
- Reset (reset=1 at an edge) forces, after that edge:
  - state=IDLE, ready=1;
  - memRd=0, memAddr=0;
  - done=0, count=0, first=0, err=0.
- Reset has priority over `start` and aborts any scan in progress. No `done` pulse follows an aborted scan.
- For n>=1:
  - memRd is high during the n cycles after E0..E(n-1), with addresses base+0..base+n-1 in order.
  - done is high during the cycle after E(n+1).
  - Total latency is n+1 cycles from the accepting edge to done.
- For n=0 or err: done is high in the cycle after E0, with no memRd.
- `ready` is low from after E0 through the DONE cycle.
- The earliest following start is the edge that ends DONE plus one, i.e. the first edge with ready=1.
- Throughput: one element per cycle; no bubbles inside SCAN.

## Test plan
- Heap [10,20,30] at array 0, size=3, key=20, mode=0 → memRd for 3 cycles at addresses 0,1,2; done in the cycle after E4; count=1, first=0, err=0.
- Same data, key=20:
  - mode 1 → count=2, first=0;
  - mode 2 → count=1, first=1;
  - mode 3 → count=1, first=2.
  - key=5, mode 0 → count=0, first=3.
- Boundaries with NAREA=3:
  - size=0 → done in the cycle after E0, count=0, first=0, no memRd.
  - size=7 → clamped to n=3, exactly 3 reads, done after E4.
  - Heap values 0 and 4095 with mode 3, key=4094 → only 4095 counts.
- With NARRAYS=2, array=1 → addresses 3,4,5.
- With NARRAYS=2, array=2 → err=1, count=0, first=0, no memRd, done in the cycle after E0.
- Control and reset:
  - start pulses during SCAN are ignored.
  - key/mode toggled mid-scan do not change the result.
  - Back-to-back scans: the second start on the first ready cycle is accepted.
  - reset asserted in the second SCAN cycle → the next cycle shows ready=1, memRd=0, done=0, count=0, and no done pulse ever appears for the aborted scan.
